ro_pair_measure_ctrl: RTL and testbench

- Challenge-driven controller for the ring-oscillator PUF.
- Drives the 4-bit select inputs of two 16:1 RO select muxes (A and B), enables the ROs, and counts synchronized rising edges of both mux outputs over a fixed window.
- Compares the two counts and emits one response bit per challenge through a start/busy/done handshake.
- Sits between the challenge/response host logic and the RO bank plus its select muxes.

---
 rtl/ro_puf_pkg.sv | 19 +
 rtl/ro_edge_counter.sv | 34 +++
 rtl/ro_pair_measure_ctrl.sv | 110 +++++++++++
 tb/tb_ro_pair_measure_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared types and constants for the RO PUF measurement path
package ro_puf_pkg;

  localparam int SEL_W  = 4;
  localparam int CHAL_W = 8;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WINDOW = 1024;
  localparam int DEF_SETTLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - synchronize an async RO output and count its rising edges (saturating)
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // sync[1] is the synchronized level, sync[2] the history flop for edge detect.
  // ROs at or above clk/2 alias here; nothing detects that.
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      count <= '0;
    end else begin
      sync <= {sync[1:0], ro};
      if (clr) begin
        count <= '0;
      end else if (en && rise && (count != {CNT_W{1'b1}})) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_pair_measure_ctrl.sv
// rtl/ro_pair_measure_ctrl.sv - challenge-driven RO pair measurement, one response bit per challenge
module ro_pair_measure_ctrl
  import ro_puf_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  output logic              busy,
  output logic              done,
  output logic              resp,
  output logic              tie,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b,
  output logic              ro_en,
  output logic [0:SEL_W-1]  sel_a,
  output logic [0:SEL_W-1]  sel_b,
  input  logic              ro_a,
  input  logic              ro_b
);

  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  state_t             state, state_next;
  logic [TMR_W-1:0]   timer;
  logic               accept;
  logic [CNT_W-1:0]   cnt_a, cnt_b;

  assign accept = (state == ST_IDLE) && start;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_SETTLE;
      ST_SETTLE:  if (timer == '0) state_next = ST_COUNT;
      ST_COUNT:   if (timer == '0) state_next = ST_COMPARE;
      ST_COMPARE: state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // busy and done are registered, so done lands one edge after the DONE state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      resp    <= 1'b0;
      tie     <= 1'b0;
      ro_en   <= 1'b0;
      count_a <= '0;
      count_b <= '0;
      sel_a   <= '0;
      sel_b   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_SETTLE) || (state_next == ST_COUNT) ||
               (state_next == ST_COMPARE);
      done  <= (state == ST_DONE);

      if (accept) begin
        timer <= TMR_W'(SETTLE - 1);
      end else if ((state == ST_SETTLE) && (timer == '0)) begin
        timer <= TMR_W'(WINDOW - 1);
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      if (accept) begin
        sel_a <= challenge[CHAL_W-1:SEL_W];
        sel_b <= challenge[SEL_W-1:0];
        ro_en <= 1'b1;
      end

      if (state == ST_COMPARE) begin
        ro_en   <= 1'b0;
        resp    <= (cnt_a > cnt_b);
        tie     <= (cnt_a == cnt_b);
        count_a <= cnt_a;
        count_b <= cnt_b;
      end
    end
  end

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_a),
    .en    (state == ST_COUNT),
    .clr   (accept),
    .count (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_b),
    .en    (state == ST_COUNT),
    .clr   (accept),
    .count (cnt_b)
  );

endmodule

// File: tb/tb_ro_pair_measure_ctrl.sv
// tb/tb_ro_pair_measure_ctrl.sv - scoreboard bench for ro_pair_measure_ctrl
module tb_ro_pair_measure_ctrl;

  typedef struct {
    int         done_cyc;
    int         amin, amax, bmin, bmax;
    bit         resp, tie, eq;
    logic [3:0] sa, sb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, start4 = 1'b0;
  logic [7:0]  challenge = 8'h00;
  logic        same = 1'b0;
  int          cyc = 0;
  int          checks = 0, errors = 0, done_seen = 0;

  int   half_a = 20, half_b = 30, half_a4 = 10, half_b4 = 40;
  logic wa = 1'b0, wb = 1'b0, wa4 = 1'b0, wb4 = 1'b0;
  logic ro_a, ro_b;

  logic        busy, done, resp, tie, ro_en;
  logic [15:0] count_a, count_b;
  logic [0:3]  sel_a, sel_b;
  logic        busy4, done4, resp4, tie4, ro_en4;
  logic [3:0]  count_a4, count_b4;
  logic [0:3]  sel_a4, sel_b4;

  exp_t q0[$], q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin #3; forever begin #(half_a) wa = ~wa; end end
  initial begin #7; forever begin #(half_b) wb = ~wb; end end
  initial begin #3; forever begin #(half_a4) wa4 = ~wa4; end end
  initial begin #1; forever begin #(half_b4) wb4 = ~wb4; end end

  assign ro_a = wa;
  assign ro_b = same ? wa : wb;

  ro_pair_measure_ctrl #(.CNT_W(16), .WINDOW(64), .SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .busy(busy), .done(done), .resp(resp), .tie(tie),
    .count_a(count_a), .count_b(count_b), .ro_en(ro_en),
    .sel_a(sel_a), .sel_b(sel_b), .ro_a(ro_a), .ro_b(ro_b)
  );

  ro_pair_measure_ctrl #(.CNT_W(4), .WINDOW(64), .SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .challenge(challenge),
    .busy(busy4), .done(done4), .resp(resp4), .tie(tie4),
    .count_a(count_a4), .count_b(count_b4), .ro_en(ro_en4),
    .sel_a(sel_a4), .sel_b(sel_b4), .ro_a(wa4), .ro_b(wb4)
  );

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      chk("done_expected", q0.size() != 0, q0.size(), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("done_latency", cyc == e0.done_cyc, cyc, e0.done_cyc);
        chk_rng("count_a", int'(count_a), e0.amin, e0.amax);
        chk_rng("count_b", int'(count_b), e0.bmin, e0.bmax);
        chk("resp", resp == e0.resp, int'(resp), int'(e0.resp));
        chk("tie", tie == e0.tie, int'(tie), int'(e0.tie));
        chk("sel_a_hold", sel_a == e0.sa, int'(sel_a), int'(e0.sa));
        chk("sel_b_hold", sel_b == e0.sb, int'(sel_b), int'(e0.sb));
        chk("ro_en_off", ro_en == 1'b0, int'(ro_en), 0);
        chk("busy_at_done", busy == 1'b0, int'(busy), 0);
        if (e0.eq) chk("count_equal", count_a == count_b, int'(count_a), int'(count_b));
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      chk("done4_expected", q1.size() != 0, q1.size(), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("done4_latency", cyc == e1.done_cyc, cyc, e1.done_cyc);
        chk_rng("count_a4", int'(count_a4), e1.amin, e1.amax);
        chk_rng("count_b4", int'(count_b4), e1.bmin, e1.bmax);
        chk("resp4", resp4 == e1.resp, int'(resp4), int'(e1.resp));
        chk("tie4", tie4 == e1.tie, int'(tie4), int'(e1.tie));
      end
    end
  end

  task automatic issue(input int which, input logic [7:0] ch, input int amin, input int amax,
                       input int bmin, input int bmax, input bit r, input bit t, input bit eq);
    exp_t e;
    e.done_cyc = cyc + 71;
    e.amin = amin; e.amax = amax; e.bmin = bmin; e.bmax = bmax;
    e.resp = r; e.tie = t; e.eq = eq;
    e.sa = ch[7:4]; e.sb = ch[3:0];
    challenge = ch;
    if (which == 0) begin start = 1'b1; q0.push_back(e); end
    else begin start4 = 1'b1; q1.push_back(e); end
    @(negedge clk);
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 300, n, 300);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int seen;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, resp, tie, ro_en} == 5'b0, int'({busy, done, resp, tie, ro_en}), 0);
    chk("reset_data", {count_a, count_b, sel_a, sel_b} == 40'b0, int'(count_a), 0);
    chk("reset4_ctrl", {busy4, done4, ro_en4, sel_a4, sel_b4} == 11'b0, int'(busy4), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // latency, selects and busy length
    issue(0, 8'hA5, 15, 16, 10, 11, 1'b1, 1'b0, 1'b0);
    chk("sel_a_accept", sel_a == 4'hA, int'(sel_a), 10);
    chk("sel_b_accept", sel_b == 4'h5, int'(sel_b), 5);
    chk("ro_en_accept", ro_en == 1'b1, int'(ro_en), 1);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("busy_cycles", n == 69, n, 69);
    drain(0);

    // swapped frequencies
    half_a = 30; half_b = 20;
    issue(0, 8'h12, 10, 11, 15, 16, 1'b0, 1'b0, 1'b0);
    drain(0);

    // identical waveform on both inputs, same select
    same = 1'b1; half_a = 40;
    issue(0, 8'h77, 7, 8, 7, 8, 1'b0, 1'b1, 1'b1);
    drain(0);
    same = 1'b0; half_a = 20; half_b = 30;

    // saturation on the narrow-counter instance
    issue(1, 8'h3E, 15, 15, 7, 8, 1'b1, 1'b0, 1'b0);
    drain(1);

    // start while busy is ignored
    issue(0, 8'h9B, 15, 16, 10, 11, 1'b1, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    challenge = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sel_a_busy_start", sel_a == 4'h9, int'(sel_a), 9);
    chk("sel_b_busy_start", sel_b == 4'hB, int'(sel_b), 11);
    drain(0);
    seen = done_seen;
    repeat (90) @(negedge clk);
    chk("no_extra_done", done_seen == seen, done_seen, seen);

    // reset in the middle of COUNT
    issue(0, 8'h5A, 15, 16, 10, 11, 1'b1, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy == 1'b0, int'(busy), 0);
    chk("abort_ctrl", {done, resp, tie, ro_en} == 4'b0, int'({done, resp, tie, ro_en}), 0);
    chk("abort_data", {count_a, count_b, sel_a, sel_b} == 40'b0, int'(count_a), 0);
    q0.delete();
    seen = done_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("no_done_after_abort", done_seen == seen, done_seen, seen);

    issue(0, 8'hC4, 15, 16, 10, 11, 1'b1, 1'b0, 1'b0);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
